// File: rtl/img_addr_pkg.sv
// Shared types for the frame-buffer address generator: FSM states, geometry
// struct and the SIZE_IMAGE geometry selector.
package img_addr_pkg;

  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    coord_t w;
    coord_t h;
  } geom_t;

  function automatic geom_t geom_sel(input logic size, input coord_t w0, input coord_t h0,
                                     input coord_t w1, input coord_t h1);
    geom_t g;
    g.w = size ? w1 : w0;
    g.h = size ? h1 : h0;
    return g;
  endfunction

endpackage

// File: rtl/img_addr_pipe.sv
// Two-stage elastic multiply-add: S1 holds y*W and x, S2 holds the byte
// address. With IMG_ADDR_BOUNDS_EN, an err-tagged beat outputs BASE_ADDR.
module img_addr_pipe
  import img_addr_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                BYTES_PER_PX = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  coord_t            x_i,
  input  coord_t            y_i,
  input  coord_t            w_i,
  input  logic              last_i,
  input  logic              err_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              err_o,
  output logic              empty_o
);

  logic              s1_v_q, s2_v_q;
  logic [ADDR_W-1:0] row_q, addr_q;
  coord_t            x1_q;
  logic              last1_q, err1_q, last2_q, err2_q;
  logic              s2_load;
  logic [ADDR_W-1:0] row_d, lin, addr_d;

  // Valid/ready: a beat moves when valid && ready; each stage loads when it is
  // empty or its current content is leaving this cycle.
  assign s2_load    = !s2_v_q || out_ready_i;
  assign in_ready_o = !s1_v_q || s2_load;

  assign row_d = ADDR_W'(y_i) * ADDR_W'(w_i);
  assign lin   = row_q + ADDR_W'(x1_q);
`ifdef IMG_ADDR_BOUNDS_EN
  assign addr_d = err1_q ? BASE_ADDR : BASE_ADDR + lin * ADDR_W'(BYTES_PER_PX);
`else
  assign addr_d = BASE_ADDR + lin * ADDR_W'(BYTES_PER_PX);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      row_q   <= '0;
      x1_q    <= '0;
      last1_q <= 1'b0;
      err1_q  <= 1'b0;
      addr_q  <= '0;
      last2_q <= 1'b0;
      err2_q  <= 1'b0;
    end else begin
      if (in_ready_o) begin
        s1_v_q <= in_valid_i;
        if (in_valid_i) begin
          row_q   <= row_d;
          x1_q    <= x_i;
          last1_q <= last_i;
          err1_q  <= err_i;
        end
      end
      if (s2_load) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          addr_q  <= addr_d;
          last2_q <= last1_q;
          err2_q  <= err1_q;
        end
      end
    end
  end

  assign out_valid_o = s2_v_q;
  assign addr_o      = addr_q;
  assign last_o      = last2_q;
  assign err_o       = err2_q;
  assign empty_o     = !s1_v_q && !s2_v_q;

endmodule

// File: rtl/img_addr_gen.sv
// Pixel {y,x} to frame-buffer byte address, in request or raster-scan mode.
// Define IMG_ADDR_BOUNDS_EN to flag out-of-frame coordinates on OUT_ERR.
module img_addr_gen
  import img_addr_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                BYTES_PER_PX = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter coord_t            W0           = 16'd640,
  parameter coord_t            H0           = 16'd480,
  parameter coord_t            W1           = 16'd1024,
  parameter coord_t            H1           = 16'd768
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SIZE_IMAGE,
  input  logic                 MODE,
  input  logic                 START,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [2*COORD_W-1:0] INDEX_ADDRESS,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [ADDR_W-1:0]    MEM_ADDRESS,
  output logic                 OUT_LAST,
  output logic                 OUT_ERR,
  output logic                 BUSY,
  output logic                 DONE,
  output state_e               DBG_STATE
);

  state_e state_q, state_d;
  geom_t  geom_q;
  coord_t sx_q, sx_d, sy_q, sy_d;
  logic   done_q, done_d;
  logic   in_ready;
  logic   p_in_valid, p_last, p_err, s1_ready, p_empty;
  coord_t p_x, p_y;

  always_comb begin
    state_d    = state_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    done_d     = 1'b0;
    p_x        = INDEX_ADDRESS[COORD_W-1:0];
    p_y        = INDEX_ADDRESS[2*COORD_W-1:COORD_W];
    p_last     = 1'b0;
    in_ready   = !RESET && !MODE && (state_q == IDLE) && s1_ready;
    p_in_valid = 1'b0;
    case (state_q)
      IDLE: begin
        p_in_valid = IN_VALID && in_ready;
        if (START && MODE && p_empty) begin
          state_d = SCAN;
          sx_d    = '0;
          sy_d    = '0;
        end
      end
      SCAN: begin
        p_x        = sx_q;
        p_y        = sy_q;
        p_in_valid = 1'b1;
        p_last     = (sx_q == geom_q.w - coord_t'(1)) && (sy_q == geom_q.h - coord_t'(1));
        if (s1_ready) begin
          if (p_last) begin
            state_d = DRAIN;
          end else if (sx_q == geom_q.w - coord_t'(1)) begin
            sx_d = '0;
            sy_d = sy_q + coord_t'(1);
          end else begin
            sx_d = sx_q + coord_t'(1);
          end
        end
      end
      DRAIN: begin
        if (OUT_VALID && OUT_READY && OUT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IMG_ADDR_BOUNDS_EN
  assign p_err = (p_x >= geom_q.w) || (p_y >= geom_q.h);
`else
  assign p_err = 1'b0;
`endif

  // Geometry tracks SIZE_IMAGE only while nothing is in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      geom_q  <= geom_sel(1'b0, W0, H0, W1, H1);
      sx_q    <= '0;
      sy_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      done_q  <= done_d;
      if (state_q == IDLE && p_empty) geom_q <= geom_sel(SIZE_IMAGE, W0, H0, W1, H1);
    end
  end

  img_addr_pipe #(
    .ADDR_W      (ADDR_W),
    .BYTES_PER_PX(BYTES_PER_PX),
    .BASE_ADDR   (BASE_ADDR)
  ) u_pipe (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .in_valid_i (p_in_valid),
    .in_ready_o (s1_ready),
    .x_i        (p_x),
    .y_i        (p_y),
    .w_i        (geom_q.w),
    .last_i     (p_last),
    .err_i      (p_err),
    .out_valid_o(OUT_VALID),
    .out_ready_i(OUT_READY),
    .addr_o     (MEM_ADDRESS),
    .last_o     (OUT_LAST),
    .err_o      (OUT_ERR),
    .empty_o    (p_empty)
  );

  assign IN_READY  = in_ready;
  assign BUSY      = (state_q != IDLE) || !p_empty;
  assign DONE      = done_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_img_addr_gen.sv
// Bench for img_addr_gen: a default-geometry instance for requests and a 4x3 / 3x2
// instance for raster scans, both scored against a plain-arithmetic address model.
module tb_img_addr_gen;
  import img_addr_pkg::*;

  localparam int AW   = 32;
  localparam int EW   = AW + 2;
  localparam int BPP  = 4;
  localparam int BASE = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_r, size_r, mode_r, start_r, in_valid_r, in_ready_r, out_valid_r, out_ready_r;
  logic          last_r, err_r, busy_r, done_r;
  logic [31:0]   idx_r;
  logic [AW-1:0] addr_r;
  state_e        dbg_r;
  logic          rst_s, size_s, mode_s, start_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s;
  logic          last_s, err_s, busy_s, done_s;
  logic [31:0]   idx_s;
  logic [AW-1:0] addr_s;
  state_e        dbg_s;

  img_addr_gen dut_r (
    .CLK(clk), .RESET(rst_r), .SIZE_IMAGE(size_r), .MODE(mode_r), .START(start_r),
    .IN_VALID(in_valid_r), .IN_READY(in_ready_r), .INDEX_ADDRESS(idx_r),
    .OUT_VALID(out_valid_r), .OUT_READY(out_ready_r), .MEM_ADDRESS(addr_r),
    .OUT_LAST(last_r), .OUT_ERR(err_r), .BUSY(busy_r), .DONE(done_r), .DBG_STATE(dbg_r)
  );

  img_addr_gen #(.W0(16'd4), .H0(16'd3), .W1(16'd3), .H1(16'd2)) dut_s (
    .CLK(clk), .RESET(rst_s), .SIZE_IMAGE(size_s), .MODE(mode_s), .START(start_s),
    .IN_VALID(in_valid_s), .IN_READY(in_ready_s), .INDEX_ADDRESS(idx_s),
    .OUT_VALID(out_valid_s), .OUT_READY(out_ready_s), .MEM_ADDRESS(addr_s),
    .OUT_LAST(last_s), .OUT_ERR(err_s), .BUSY(busy_s), .DONE(done_s), .DBG_STATE(dbg_s)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_r_q[$];
  logic [EW-1:0] exp_s_q[$];
  int unsigned gw_r = 640, gh_r = 480;
  int beats_r = 0, acc_r = 0, stall_cnt = 0;
  int done_cnt_s = 0, ir_bad_s = 0;
  bit rnd_r = 0, rdy_r = 1, rnd_s = 0, rdy_s = 1, scan_on = 0;

  // Reference: linear pixel index times stride plus base, wrapped to AW bits.
  function automatic logic [EW-1:0] model(input int unsigned x, input int unsigned y,
                                          input int unsigned w, input int unsigned h,
                                          input bit last);
    longint unsigned p;
    logic [AW-1:0]   a;
    bit              err;
    err = 1'b0;
    p   = longint'(y) * w + x;
    p   = p * BPP + BASE;
    a   = p[AW-1:0];
`ifdef IMG_ADDR_BOUNDS_EN
    if (x >= w || y >= h) begin
      err = 1'b1;
      a   = AW'(BASE);
    end
`endif
    return {err, last, a};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready_r = rnd_r ? 1'($urandom_range(0, 1)) : rdy_r;
    out_ready_s = rnd_s ? 1'($urandom_range(0, 1)) : rdy_s;
  end

  // Monitors: pop on each transfer, hold-stability while stalled, DONE timing.
  logic [EW-1:0] held_r, held_s, e_r, e_s;
  bit stall_r = 0, stall_s = 0, done_exp_s = 0;

  always @(negedge clk) begin
    if (rst_r) begin
      stall_r = 0;
    end else begin
      if (stall_r) check("r_stable", {out_valid_r, err_r, last_r, addr_r}, {1'b1, held_r});
      if (out_valid_r && out_ready_r) begin
        if (exp_r_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got beat 0x%0h, expected none", addr_r);
        end else begin
          e_r = exp_r_q.pop_front();
          check("r_beat", {err_r, last_r, addr_r}, e_r);
          beats_r++;
        end
      end
      stall_r = out_valid_r && !out_ready_r;
      held_r  = {err_r, last_r, addr_r};
    end
  end

  always @(negedge clk) begin
    if (rst_s) begin
      stall_s    = 0;
      done_exp_s = 0;
    end else begin
      if (stall_s) check("s_stable", {out_valid_s, err_s, last_s, addr_s}, {1'b1, held_s});
      if (done_s || done_exp_s) check("s_done", done_s, done_exp_s);
      if (done_s) done_cnt_s++;
      if (scan_on && in_ready_s) ir_bad_s++;
      if (out_valid_s && out_ready_s) begin
        if (exp_s_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL s_unexpected: got beat 0x%0h, expected none", addr_s);
        end else begin
          e_s = exp_s_q.pop_front();
          check("s_beat", {err_s, last_s, addr_s}, e_s);
        end
      end
      done_exp_s = out_valid_s && out_ready_s && last_s;
      stall_s    = out_valid_s && !out_ready_s;
      held_s     = {err_s, last_s, addr_s};
    end
  end

  task automatic issue_r(input int unsigned y, input int unsigned x);
    int n;
    n = 0;
    @(posedge clk); #1;
    idx_r      = {y[15:0], x[15:0]};
    in_valid_r = 1'b1;
    @(negedge clk);
    while (!in_ready_r && n < 60) begin
      n++; stall_cnt++;
      @(negedge clk);
    end
    if (in_ready_r) begin
      exp_r_q.push_back(model(x, y, gw_r, gh_r, 1'b0));
      acc_r++;
    end else begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic idle_r();
    @(posedge clk); #1;
    in_valid_r = 1'b0;
  endtask

  task automatic drain_r();
    int n;
    n = 0;
    while ((exp_r_q.size() != 0 || busy_r) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("r_drain_left", exp_r_q.size(), 0);
    check("r_drain_busy", busy_r, 1'b0);
  endtask

  task automatic set_size_r(input bit sz);
    size_r = sz;
    gw_r   = sz ? 1024 : 640;
    gh_r   = sz ? 768 : 480;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_scan_s(input int unsigned w, input int unsigned h, input bit flip);
    int n, d0;
    for (int y = 0; y < int'(h); y++)
      for (int x = 0; x < int'(w); x++)
        exp_s_q.push_back(model(x, y, w, h, (x == int'(w) - 1) && (y == int'(h) - 1)));
    d0       = done_cnt_s;
    ir_bad_s = 0;
    @(posedge clk); #1;
    start_s    = 1'b1;
    in_valid_s = 1'b1;
    idx_s      = $urandom;
    scan_on    = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    if (flip) begin
      repeat (3) @(posedge clk);
      size_s = ~size_s;
    end
    n = 0;
    while (done_cnt_s == d0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check("scan_done_count", done_cnt_s - d0, 1);
    check("scan_exp_left", exp_s_q.size(), 0);
    check("scan_in_ready", ir_bad_s, 0);
    scan_on    = 1'b0;
    in_valid_s = 1'b0;
  endtask

  initial begin
    int b0, s0, a0, d0;
    rst_r = 1; rst_s = 1; size_r = 0; size_s = 0; mode_r = 0; mode_s = 1;
    start_r = 0; start_s = 0; in_valid_r = 0; in_valid_s = 0; idx_r = '0; idx_s = '0;
    repeat (3) @(posedge clk);
    #1;
    check("r_reset_outs", {out_valid_r, last_r, err_r, busy_r, done_r, in_ready_r, addr_r}, '0);
    check("s_reset_outs", {out_valid_s, last_s, err_s, busy_s, done_s, in_ready_s, addr_s}, '0);
    check("r_reset_state", dbg_r, IDLE);
    @(posedge clk); #1;
    rst_r = 0; rst_s = 0;
    repeat (2) @(posedge clk);

    // Single request: latency and the documented address.
    s0 = stall_cnt;
    issue_r(2, 3);
    check("t1_accept_now", stall_cnt - s0, 0);
    idle_r();
    @(negedge clk); #1;
    check("t1_valid_c1", out_valid_r, 1'b0);
    @(negedge clk); #1;
    check("t1_valid_c2", out_valid_r, 1'b1);
    check("t1_addr", addr_r, 32'd5132);
    drain_r();

    // Large geometry, corner pixel, back-to-back throughput.
    set_size_r(1);
    b0 = beats_r; s0 = stall_cnt;
    issue_r(767, 1023);
    for (int i = 0; i < 7; i++) issue_r($urandom_range(0, 767), $urandom_range(0, 1023));
    idle_r();
    repeat (2) @(negedge clk);
    #1;
    check("t2_stalls", stall_cnt - s0, 0);
    check("t2_beats", beats_r - b0, 8);
    drain_r();

    // Backpressure: two beats absorbed, then IN_READY drops.
    set_size_r(0);
    rdy_r = 0;
    repeat (2) @(posedge clk);
    a0 = acc_r;
    fork
      begin
        for (int i = 0; i < 4; i++) issue_r($urandom_range(0, 479), $urandom_range(0, 639));
        idle_r();
      end
      begin
        repeat (6) @(negedge clk);
        #1;
        check("t3_accepted", acc_r - a0, 2);
        check("t3_in_ready", in_ready_r, 1'b0);
        rdy_r = 1;
      end
    join
    drain_r();

    // Out-of-frame coordinates.
    issue_r(0, 640);
    issue_r(480, 5);
    idle_r();
    drain_r();

    // Randomized requests with random backpressure and gaps.
    rnd_r = 1;
    for (int b = 0; b < 4; b++) begin
      set_size_r(b[0]);
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 3) == 0) idle_r();
        issue_r($urandom_range(0, gh_r + gh_r / 16), $urandom_range(0, gw_r + gw_r / 16));
      end
      idle_r();
      drain_r();
    end
    rnd_r = 0;

    // Raster scans: geometry frozen while busy, then smaller geometry with backpressure.
    run_scan_s(4, 3, 1'b1);
    size_s = 1'b1;
    repeat (3) @(posedge clk);
    rnd_s = 1;
    run_scan_s(3, 2, 1'b0);
    rnd_s  = 0;
    size_s = 1'b0;
    repeat (3) @(posedge clk);

    // Reset mid-scan aborts without DONE; a fresh START rescans from 0.
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) exp_s_q.push_back(model(x, y, 4, 3, (x == 3) && (y == 2)));
    @(posedge clk); #1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst_s = 1'b1;
    #1;
    check("t6_reset_outs", {out_valid_s, last_s, err_s, busy_s, done_s, in_ready_s, addr_s}, '0);
    check("t6_reset_state", dbg_s, IDLE);
    exp_s_q.delete();
    d0     = done_cnt_s;
    size_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_s  = 1'b0;
    size_s = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("t6_no_done", done_cnt_s - d0, 0);
    check("t6_idle_busy", busy_s, 1'b0);
    rnd_s = 1;
    run_scan_s(4, 3, 1'b0);
    rnd_s = 0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
